// File: rtl/bus_arbiter.sv
// Two-requester arbiter for the single TileLink master port.
// m0 is instruction fetch and m1 is the data agent. One transaction is in flight at a time.
module bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_request,
    input  logic              m0_a_valid,
    output logic              m0_a_ready,
    input  logic [2:0]        m0_a_opcode,
    input  logic [ADDR_W-1:0] m0_a_address,
    input  logic [DATA_W-1:0] m0_a_data,
    output logic              m0_d_valid,
    output logic [2:0]        m0_d_opcode,
    output logic [1:0]        m0_d_param,
    output logic [DATA_W-1:0] m0_d_data,
    output logic              m0_err,

    input  logic              m1_request,
    input  logic              m1_a_valid,
    output logic              m1_a_ready,
    input  logic [2:0]        m1_a_opcode,
    input  logic [ADDR_W-1:0] m1_a_address,
    input  logic [DATA_W-1:0] m1_a_data,
    output logic              m1_d_valid,
    output logic [2:0]        m1_d_opcode,
    output logic [1:0]        m1_d_param,
    output logic [DATA_W-1:0] m1_d_data,
    output logic              m1_err,

    output logic              bus_a_valid,
    input  logic              bus_a_ready,
    output logic [2:0]        bus_a_opcode,
    output logic [ADDR_W-1:0] bus_a_address,
    output logic [DATA_W-1:0] bus_a_data,
    input  logic              bus_d_valid,
    output logic              bus_d_ready,
    input  logic [2:0]        bus_d_opcode,
    input  logic [1:0]        bus_d_param,
    input  logic [DATA_W-1:0] bus_d_data
);

    // A TIMEOUT of zero disables the watchdog. A one-bit timer keeps the width legal in that case.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] T_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_grant;      // 0 = m0, 1 = m1; only meaningful outside IDLE
    logic          w_grant_nxt;
    logic          r_prio;       // winner of the next contended arbitration
    logic          w_prio_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;

    // The A-channel of the granted requester, selected once for reuse below.
    logic              w_g_request;
    logic              w_g_a_valid;
    logic [2:0]        w_g_a_opcode;
    logic [ADDR_W-1:0] w_g_a_address;
    logic [DATA_W-1:0] w_g_a_data;

    assign w_g_request   = r_grant ? m1_request   : m0_request;
    assign w_g_a_valid   = r_grant ? m1_a_valid   : m0_a_valid;
    assign w_g_a_opcode  = r_grant ? m1_a_opcode  : m0_a_opcode;
    assign w_g_a_address = r_grant ? m1_a_address : m0_a_address;
    assign w_g_a_data    = r_grant ? m1_a_data    : m0_a_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_prio  <= 1'b1;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_prio  <= w_prio_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // NOTE: every signal driven here receives a default first. Any path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_prio_nxt    = r_prio;
        w_timer_nxt   = r_timer;

        bus_a_valid   = 1'b0;
        bus_a_opcode  = '0;
        bus_a_address = '0;
        bus_a_data    = '0;
        bus_d_ready   = 1'b0;

        m0_a_ready    = 1'b0;
        m0_d_valid    = 1'b0;
        m0_d_opcode   = '0;
        m0_d_param    = '0;
        m0_d_data     = '0;
        m0_err        = 1'b0;

        m1_a_ready    = 1'b0;
        m1_d_valid    = 1'b0;
        m1_d_opcode   = '0;
        m1_d_param    = '0;
        m1_d_data     = '0;
        m1_err        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (m0_request && m1_request) begin
                    w_grant_nxt = r_prio;
                    w_prio_nxt  = ~r_prio;
                    w_state_nxt = S_ADDR;
                end else if (m0_request) begin
                    w_grant_nxt = 1'b0;
                    w_state_nxt = S_ADDR;
                end else if (m1_request) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end

            S_ADDR: begin
                if (!w_g_request) begin
                    // The requester withdrew before acceptance, so nothing reaches the bus.
                    w_state_nxt = S_IDLE;
                end else begin
                    bus_a_valid   = w_g_a_valid;
                    bus_a_opcode  = w_g_a_opcode;
                    bus_a_address = w_g_a_address;
                    bus_a_data    = w_g_a_data;
                    if (r_grant) m1_a_ready = bus_a_ready;
                    else         m0_a_ready = bus_a_ready;
                    if (w_g_a_valid && bus_a_ready) begin
                        w_state_nxt = S_BUSY;
                        w_timer_nxt = '0;
                    end
                end
            end

            S_BUSY: begin
                bus_d_ready = 1'b1;
                if (r_grant) begin
                    m1_d_valid  = bus_d_valid;
                    m1_d_opcode = bus_d_opcode;
                    m1_d_param  = bus_d_param;
                    m1_d_data   = bus_d_data;
                end else begin
                    m0_d_valid  = bus_d_valid;
                    m0_d_opcode = bus_d_opcode;
                    m0_d_param  = bus_d_param;
                    m0_d_data   = bus_d_data;
                end

                if (bus_d_valid) begin
                    w_state_nxt = S_IDLE;
                end else if ((TIMEOUT != 0) && (r_timer == T_LAST)) begin
                    if (r_grant) m1_err = 1'b1;
                    else         m0_err = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer != T_MAX) begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table, then hand-written
// sequences for stall, watchdog, asynchronous reset and request withdrawal.
module tb_bus_arbiter;

    localparam logic [63:0] A0 = 64'h0000_0000_0000_1000;
    localparam logic [63:0] A1 = 64'h0000_0000_8000_0000;
    localparam int NROWS = 17;

    logic        clk;
    logic        rst_n;
    logic        m0_request, m0_a_valid, m0_a_ready;
    logic [2:0]  m0_a_opcode;
    logic [63:0] m0_a_address, m0_a_data;
    logic        m0_d_valid;
    logic [2:0]  m0_d_opcode;
    logic [1:0]  m0_d_param;
    logic [63:0] m0_d_data;
    logic        m0_err;
    logic        m1_request, m1_a_valid, m1_a_ready;
    logic [2:0]  m1_a_opcode;
    logic [63:0] m1_a_address, m1_a_data;
    logic        m1_d_valid;
    logic [2:0]  m1_d_opcode;
    logic [1:0]  m1_d_param;
    logic [63:0] m1_d_data;
    logic        m1_err;
    logic        bus_a_valid, bus_a_ready;
    logic [2:0]  bus_a_opcode;
    logic [63:0] bus_a_address, bus_a_data;
    logic        bus_d_valid, bus_d_ready;
    logic [2:0]  bus_d_opcode;
    logic [1:0]  bus_d_param;
    logic [63:0] bus_d_data;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_request(m0_request), .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
        .m0_a_opcode(m0_a_opcode), .m0_a_address(m0_a_address), .m0_a_data(m0_a_data),
        .m0_d_valid(m0_d_valid), .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param),
        .m0_d_data(m0_d_data), .m0_err(m0_err),
        .m1_request(m1_request), .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
        .m1_a_opcode(m1_a_opcode), .m1_a_address(m1_a_address), .m1_a_data(m1_a_data),
        .m1_d_valid(m1_d_valid), .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param),
        .m1_d_data(m1_d_data), .m1_err(m1_err),
        .bus_a_valid(bus_a_valid), .bus_a_ready(bus_a_ready), .bus_a_opcode(bus_a_opcode),
        .bus_a_address(bus_a_address), .bus_a_data(bus_a_data),
        .bus_d_valid(bus_d_valid), .bus_d_ready(bus_d_ready), .bus_d_opcode(bus_d_opcode),
        .bus_d_param(bus_d_param), .bus_d_data(bus_d_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus_a_valid && bus_a_ready) hs_cnt <= hs_cnt + 1;

    typedef struct {
        logic        m0r, m0v, m1r, m1v, ard, dv;
        logic [15:0] dat;
        logic        e_av, e_m0ar, e_m1ar, e_m0dv, e_m1dv, e_drdy;
        logic [63:0] e_addr;
    } row_t;

    row_t rows [NROWS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic clear_inputs;
        m0_request = 0; m0_a_valid = 0; m1_request = 0; m1_a_valid = 0;
        bus_a_ready = 0; bus_d_valid = 0; bus_d_data = '0; bus_d_param = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        m0_a_opcode = 3'd4; m0_a_address = A0; m0_a_data = '0;
        m1_a_opcode = 3'd4; m1_a_address = A1; m1_a_data = 64'h1234;
        bus_d_opcode = 3'd1;
        clear_inputs();

        // Each row describes one cycle: the inputs, then the outputs expected in that cycle.
        rows[0]  = '{0,0,0,0,0,0,16'h0000, 0,0,0,0,0,0, 64'h0};
        rows[1]  = '{0,0,1,1,1,0,16'h0000, 0,0,0,0,0,0, 64'h0};
        rows[2]  = '{0,0,1,1,1,0,16'h0000, 1,0,1,0,0,0, A1};
        rows[3]  = '{0,0,1,0,1,0,16'h0000, 0,0,0,0,0,1, 64'h0};
        rows[4]  = '{0,0,1,0,1,0,16'h0000, 0,0,0,0,0,1, 64'h0};
        rows[5]  = '{0,0,1,0,1,1,16'hDEAD, 0,0,0,0,1,1, 64'h0};
        rows[6]  = '{0,0,0,0,1,0,16'h0000, 0,0,0,0,0,0, 64'h0};
        rows[7]  = '{1,1,1,1,1,0,16'h0000, 0,0,0,0,0,0, 64'h0};
        rows[8]  = '{1,1,1,1,1,0,16'h0000, 1,0,1,0,0,0, A1};
        rows[9]  = '{1,1,1,1,1,1,16'h1111, 0,0,0,0,1,1, 64'h0};
        rows[10] = '{1,1,1,1,1,0,16'h0000, 0,0,0,0,0,0, 64'h0};
        rows[11] = '{1,1,1,1,1,0,16'h0000, 1,1,0,0,0,0, A0};
        rows[12] = '{1,1,1,1,1,1,16'h2222, 0,0,0,1,0,1, 64'h0};
        rows[13] = '{1,1,1,1,1,0,16'h0000, 0,0,0,0,0,0, 64'h0};
        rows[14] = '{1,1,1,1,1,0,16'h0000, 1,0,1,0,0,0, A1};
        rows[15] = '{1,1,1,1,1,1,16'h3333, 0,0,0,0,1,1, 64'h0};
        rows[16] = '{0,0,0,0,0,1,16'hBEEF, 0,0,0,0,0,0, 64'h0};

        rst_n = 1'b0;
        #2;
        check("reset bus_a_valid", bus_a_valid, 0);
        check("reset bus_d_ready", bus_d_ready, 0);
        check("reset m1_err", m1_err, 0);
        do_reset();

        for (int i = 0; i < NROWS; i++) begin
            m0_request  = rows[i].m0r;
            m0_a_valid  = rows[i].m0v;
            m1_request  = rows[i].m1r;
            m1_a_valid  = rows[i].m1v;
            bus_a_ready = rows[i].ard;
            bus_d_valid = rows[i].dv;
            bus_d_data  = 64'(rows[i].dat);
            settle();
            check($sformatf("row%0d bus_a_valid", i), bus_a_valid, rows[i].e_av);
            check($sformatf("row%0d bus_a_address", i), bus_a_address, rows[i].e_addr);
            check($sformatf("row%0d m0_a_ready", i), m0_a_ready, rows[i].e_m0ar);
            check($sformatf("row%0d m1_a_ready", i), m1_a_ready, rows[i].e_m1ar);
            check($sformatf("row%0d m0_d_valid", i), m0_d_valid, rows[i].e_m0dv);
            check($sformatf("row%0d m1_d_valid", i), m1_d_valid, rows[i].e_m1dv);
            check($sformatf("row%0d bus_d_ready", i), bus_d_ready, rows[i].e_drdy);
            check($sformatf("row%0d m0_d_data", i), m0_d_data,
                  rows[i].e_m0dv ? 64'(rows[i].dat) : 64'h0);
            check($sformatf("row%0d m1_d_data", i), m1_d_data,
                  rows[i].e_m1dv ? 64'(rows[i].dat) : 64'h0);
            check($sformatf("row%0d errs", i), {m0_err, m1_err}, 0);
            tick();
        end

        // A stall in ADDR(1) under contention: m1 keeps the bus and m0 never gets it.
        do_reset();
        m0_request = 1; m0_a_valid = 1; m1_request = 1; m1_a_valid = 1; bus_a_ready = 0;
        settle();
        check("stall idle bus_a_valid", bus_a_valid, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            bus_d_valid = (k >= 2);
            bus_d_data  = 64'h99;
            settle();
            check($sformatf("stall%0d bus_a_valid", k), bus_a_valid, 1);
            check($sformatf("stall%0d bus_a_address", k), bus_a_address, A1);
            check($sformatf("stall%0d bus_a_opcode", k), bus_a_opcode, 4);
            check($sformatf("stall%0d m1_a_ready", k), m1_a_ready, 0);
            check($sformatf("stall%0d m0_a_ready", k), m0_a_ready, 0);
            check($sformatf("stall%0d d_fwd", k), {m0_d_valid, m1_d_valid, bus_d_ready}, 0);
            tick();
        end
        bus_d_valid = 0; bus_a_ready = 1;
        settle();
        check("stall accept m1_a_ready", m1_a_ready, 1);
        check("stall accept m0_a_ready", m0_a_ready, 0);
        tick();
        bus_d_valid = 1; bus_d_data = 64'h55; bus_d_param = 2'b01;
        settle();
        check("stall d m1_d_valid", m1_d_valid, 1);
        check("stall d m1_d_param", m1_d_param, 2'b01);
        check("stall d m0_d_valid", m0_d_valid, 0);
        tick();
        bus_d_valid = 0;
        settle();
        check("stall after idle bus_a_valid", bus_a_valid, 0);
        tick();

        // The watchdog fires on the 8th BUSY cycle. A request dropped mid-BUSY does not release the grant.
        do_reset();
        m1_request = 1; m1_a_valid = 1; bus_a_ready = 1;
        tick();
        settle();
        check("wd addr bus_a_valid", bus_a_valid, 1);
        tick();
        m1_a_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) m1_request = 0;
            settle();
            check($sformatf("wd busy%0d bus_d_ready", k), bus_d_ready, 1);
            check($sformatf("wd busy%0d m1_err", k), m1_err, (k == 8));
            check($sformatf("wd busy%0d m0_err", k), m0_err, 0);
            tick();
        end
        settle();
        check("wd idle bus_d_ready", bus_d_ready, 0);
        check("wd idle m1_err", m1_err, 0);
        tick();
        bus_d_valid = 1; bus_d_data = 64'hAA;
        settle();
        check("wd late d m1_d_valid", m1_d_valid, 0);
        check("wd late d bus_d_ready", bus_d_ready, 0);
        tick();
        bus_d_valid = 0;

        // Asynchronous reset while in BUSY(0), then a clean retry.
        do_reset();
        m0_request = 1; m0_a_valid = 1; bus_a_ready = 1;
        tick();
        settle();
        check("rst addr m0_a_ready", m0_a_ready, 1);
        tick();
        m0_a_valid = 0;
        settle();
        check("rst busy bus_d_ready", bus_d_ready, 1);
        #1 rst_n = 1'b0; bus_d_valid = 1; bus_d_data = 64'h66;
        #1;
        check("rst async bus_d_ready", bus_d_ready, 0);
        check("rst async m0_d_valid", m0_d_valid, 0);
        check("rst async bus_a_valid", bus_a_valid, 0);
        bus_d_valid = 0; m0_request = 0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        m0_request = 1; m0_a_valid = 1;
        settle();
        check("rst retry idle bus_a_valid", bus_a_valid, 0);
        tick();
        settle();
        check("rst retry bus_a_address", bus_a_address, A0);
        check("rst retry m0_a_ready", m0_a_ready, 1);
        tick();
        m0_a_valid = 0; bus_d_valid = 1; bus_d_data = 64'h77;
        settle();
        check("rst retry m0_d_valid", m0_d_valid, 1);
        check("rst retry m0_d_data", m0_d_data, 64'h77);
        tick();
        bus_d_valid = 0; m0_request = 0;

        // m0 withdraws in ADDR before the bus accepts, so no handshake happens.
        do_reset();
        m0_request = 1; m0_a_valid = 1; bus_a_ready = 0;
        tick();
        settle();
        check("drop addr bus_a_valid", bus_a_valid, 1);
        tick();
        begin
            int hs0;
            hs0 = hs_cnt;
            m0_request = 0; bus_a_ready = 1;
            settle();
            check("drop bus_a_valid", bus_a_valid, 0);
            check("drop m0_a_ready", m0_a_ready, 0);
            tick();
            settle();
            check("drop idle bus_d_ready", bus_d_ready, 0);
            check("drop idle bus_a_valid", bus_a_valid, 0);
            check("drop handshakes", hs_cnt, hs0);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
